// File: rtl/proc_hier_top_if.sv
// Architectural trace bundle of the multi-cycle core: register writes, data accesses, halt, cycle count.
// The master side is driven by the core; the slave side is sampled by loggers and benches.
interface proc_hier_top_if;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        halt;
  logic [31:0] cycle_count;

  modport master (
    output pc, inst, reg_write, write_reg, write_data,
    output mem_read, mem_write, mem_addr, mem_data_in, mem_data_out,
    output halt, cycle_count
  );

  modport slave (
    input pc, inst, reg_write, write_reg, write_data,
    input mem_read, mem_write, mem_addr, mem_data_in, mem_data_out,
    input halt, cycle_count
  );
endinterface

// File: rtl/proc_hier_top.sv
// 16-bit multi-cycle core (FETCH/EXEC/MEM/WB, 4 cycles per instruction) with a zero-wait unified memory.
// No backpressure: memory always completes in the cycle it is accessed; the image is preloaded by the environment.
module proc_hier_top #(
  parameter int    MEM_WORDS = 65536,
  parameter string INIT_FILE = "loadfile_all.img"
) (
  input  logic            clk,
  input  logic            rst_n,
  proc_hier_top_if.master trc
);

  localparam int AddrW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [4:0] OpHalt  = 5'b00000;
  localparam logic [4:0] OpAddi  = 5'b01000;
  localparam logic [4:0] OpSubi  = 5'b01001;
  localparam logic [4:0] OpXori  = 5'b01010;
  localparam logic [4:0] OpAndni = 5'b01011;
  localparam logic [4:0] OpSt    = 5'b10000;
  localparam logic [4:0] OpLd    = 5'b10001;
  localparam logic [4:0] OpRtype = 5'b11011;
  localparam logic [4:0] OpLbi   = 5'b11000;
  localparam logic [4:0] OpBeqz  = 5'b01100;
  localparam logic [4:0] OpBnez  = 5'b01101;
  localparam logic [4:0] OpJ     = 5'b00100;

  typedef enum logic [2:0] {
    Fetch  = 3'd0,
    Exec   = 3'd1,
    Mem    = 3'd2,
    Wb     = 3'd3,
    Halted = 3'd4
  } state_t;

  function automatic logic [AddrW-1:0] wordIndex(input logic [15:0] byteAddr);
    logic [31:0] idx;
    idx = {16'd0, byteAddr} >> 1;
    idx = idx % 32'(MEM_WORDS);
    return AddrW'(idx);
  endfunction

  state_t      state;
  state_t      nextState;

  logic [15:0] mem [MEM_WORDS];
  logic [15:0] regFile [8];
  logic [15:0] pcReg;
  logic [15:0] instReg;
  logic [31:0] cycleCnt;

  // Results captured at the end of EXEC and consumed in MEM/WB.
  logic [15:0] resultReg;
  logic [15:0] storeReg;
  logic [15:0] nextPcReg;
  logic [2:0]  dstReg;
  logic        wrReg;
  logic        ldReg;
  logic        stReg;
  logic        haltReg;

  logic [4:0]  opcode;
  logic [15:0] rsVal;
  logic [15:0] rtVal;
  logic [15:0] imm5S;
  logic [15:0] imm5Z;
  logic [15:0] imm8S;
  logic [15:0] disp11S;
  logic [15:0] pcPlus2;
  logic [15:0] decResult;
  logic [15:0] decStore;
  logic [15:0] decNextPc;
  logic [2:0]  decDst;
  logic        decWr;
  logic        decLd;
  logic        decSt;
  logic        decHalt;

  logic [15:0] fetchWord;
  logic [15:0] memRdData;
  logic        memRdStb;
  logic        memWrStb;
  logic        regWrStb;
  logic        haltStb;

  assign fetchWord = mem[wordIndex(pcReg)];
  assign memRdData = mem[wordIndex(resultReg)];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= Fetch;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    memRdStb  = 1'b0;
    memWrStb  = 1'b0;
    regWrStb  = 1'b0;
    haltStb   = 1'b0;
    case (state)
      Fetch: nextState = Exec;
      Exec:  nextState = Mem;
      Mem: begin
        memRdStb  = ldReg;
        memWrStb  = stReg;
        haltStb   = haltReg;
        nextState = haltReg ? Halted : Wb;
      end
      Wb: begin
        regWrStb  = wrReg;
        nextState = Fetch;
      end
      Halted:  nextState = Halted;
      default: nextState = Fetch;
    endcase
    // A reset in flight must not leak a strobe (or a memory write) into this edge.
    if (!rst_n) begin
      memRdStb = 1'b0;
      memWrStb = 1'b0;
      regWrStb = 1'b0;
      haltStb  = 1'b0;
    end
  end

  always_comb begin
    opcode    = instReg[15:11];
    rsVal     = regFile[instReg[10:8]];
    rtVal     = regFile[instReg[7:5]];
    imm5S     = {{11{instReg[4]}}, instReg[4:0]};
    imm5Z     = {11'd0, instReg[4:0]};
    imm8S     = {{8{instReg[7]}}, instReg[7:0]};
    disp11S   = {{5{instReg[10]}}, instReg[10:0]};
    pcPlus2   = pcReg + 16'd2;
    decResult = 16'd0;
    decStore  = rtVal;
    decNextPc = pcPlus2;
    decDst    = instReg[7:5];
    decWr     = 1'b0;
    decLd     = 1'b0;
    decSt     = 1'b0;
    decHalt   = 1'b0;
    case (opcode)
      OpHalt: decHalt = 1'b1;
      OpAddi: begin
        decResult = rsVal + imm5S;
        decWr     = 1'b1;
      end
      OpSubi: begin
        decResult = imm5S - rsVal;
        decWr     = 1'b1;
      end
      OpXori: begin
        decResult = rsVal ^ imm5Z;
        decWr     = 1'b1;
      end
      OpAndni: begin
        decResult = rsVal & ~imm5Z;
        decWr     = 1'b1;
      end
      OpSt: begin
        decResult = rsVal + imm5S;
        decSt     = 1'b1;
      end
      OpLd: begin
        decResult = rsVal + imm5S;
        decLd     = 1'b1;
        decWr     = 1'b1;
      end
      OpRtype: begin
        decDst = instReg[4:2];
        decWr  = 1'b1;
        case (instReg[1:0])
          2'b00:   decResult = rsVal + rtVal;
          2'b01:   decResult = rtVal - rsVal;
          2'b10:   decResult = rsVal ^ rtVal;
          default: decResult = rsVal & ~rtVal;
        endcase
      end
      OpLbi: begin
        decResult = imm8S;
        decDst    = instReg[10:8];
        decWr     = 1'b1;
      end
      OpBeqz: if (rsVal == 16'd0) decNextPc = pcPlus2 + imm8S;
      OpBnez: if (rsVal != 16'd0) decNextPc = pcPlus2 + imm8S;
      OpJ:    decNextPc = pcPlus2 + disp11S;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcReg     <= 16'd0;
      instReg   <= 16'h0800;
      cycleCnt  <= 32'd0;
      resultReg <= 16'd0;
      storeReg  <= 16'd0;
      nextPcReg <= 16'd0;
      dstReg    <= 3'd0;
      wrReg     <= 1'b0;
      ldReg     <= 1'b0;
      stReg     <= 1'b0;
      haltReg   <= 1'b0;
      for (int i = 0; i < 8; i++) regFile[i] <= 16'd0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      case (state)
        Fetch: instReg <= fetchWord;
        Exec: begin
          resultReg <= decResult;
          storeReg  <= decStore;
          nextPcReg <= decNextPc;
          dstReg    <= decDst;
          wrReg     <= decWr;
          ldReg     <= decLd;
          stReg     <= decSt;
          haltReg   <= decHalt;
        end
        Mem: if (ldReg) resultReg <= memRdData;
        Wb: begin
          if (regWrStb) regFile[dstReg] <= resultReg;
          pcReg <= nextPcReg;
        end
        default: ;
      endcase
    end
  end

  // Memory contents survive reset; only the gated store strobe may change them.
  always_ff @(posedge clk) begin
    if (memWrStb) mem[wordIndex(resultReg)] <= storeReg;
  end

  assign trc.pc           = pcReg;
  assign trc.inst         = instReg;
  assign trc.reg_write    = regWrStb;
  assign trc.write_reg    = dstReg;
  assign trc.write_data   = resultReg;
  assign trc.mem_read     = memRdStb;
  assign trc.mem_write    = memWrStb;
  assign trc.mem_addr     = resultReg;
  assign trc.mem_data_in  = storeReg;
  assign trc.mem_data_out = memRdData;
  assign trc.halt         = haltStb;
  assign trc.cycle_count  = cycleCnt;

endmodule

// File: tb/tb_proc_hier_top.sv
// Bench for proc_hier_top: a program table feeds a trace scoreboard, plus hand sequences for
// halt timing, a self-loop jump and a reset that lands on the MEM cycle of a store.
module tb_proc_hier_top;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  proc_hier_top_if trc ();

  proc_hier_top #(
    .MEM_WORDS(65536),
    .INIT_FILE("loadfile_all.img")
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .trc  (trc.master)
  );

  typedef enum int {EvNone, EvReg, EvSt, EvLd, EvHalt, EvSkip} evKind_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] inst;
    evKind_t     kind;
    logic [2:0]  idx;
    logic [15:0] val;
    logic [15:0] maddr;
  } vec_t;

  typedef struct {
    evKind_t     kind;
    logic [2:0]  idx;
    logic [15:0] data;
    logic [15:0] addr;
  } ev_t;

  ev_t         evQ[$];
  logic [15:0] pcQ[$];
  int          tests = 0;
  int          fails = 0;
  logic        monEn = 1'b0;
  logic        sawHalt = 1'b0;
  logic [31:0] haltCycle = 32'd0;
  logic [31:0] tbCycle = 32'd0;
  logic [15:0] expPc;

  always @(posedge clk) tbCycle <= rst_n ? tbCycle + 32'd1 : 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, tbCycle);
    end
  endtask

  task automatic popEv(input evKind_t kind, input logic [2:0] idx, input logic [15:0] data,
                       input logic [15:0] addr);
    ev_t e;
    if (evQ.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d data %h addr %h, expected none (cycle %0d)",
               kind, data, addr, tbCycle);
    end else begin
      e = evQ.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == EvReg) begin
        chk("write_reg", {29'd0, idx}, {29'd0, e.idx});
        chk("write_data", {16'd0, data}, {16'd0, e.data});
      end else if (e.kind == EvSt || e.kind == EvLd) begin
        chk("mem_addr", {16'd0, addr}, {16'd0, e.addr});
        chk("mem_data", {16'd0, data}, {16'd0, e.data});
      end
    end
  endtask

  always @(negedge clk) begin
    if (monEn && rst_n) begin
      chk("cycle_count", trc.cycle_count, tbCycle);
      chk("rd_wr_exclusive", {31'd0, trc.mem_read & trc.mem_write}, 32'd0);
      if (tbCycle[1:0] == 2'd0 && pcQ.size() > 0) begin
        expPc = pcQ.pop_front();
        chk("fetch_pc", {16'd0, trc.pc}, {16'd0, expPc});
      end
      if (trc.reg_write) popEv(EvReg, trc.write_reg, trc.write_data, 16'h0000);
      if (trc.mem_write) popEv(EvSt, 3'd0, trc.mem_data_in, trc.mem_addr);
      if (trc.mem_read)  popEv(EvLd, 3'd0, trc.mem_data_out, trc.mem_addr);
      if (trc.halt) begin
        popEv(EvHalt, 3'd0, 16'h0000, 16'h0000);
        if (!sawHalt) haltCycle = tbCycle;
        sawHalt = 1'b1;
      end
    end
  end

  task automatic enterReset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitHalt(input int budget);
    for (int i = 0; i < budget && !sawHalt; i++) @(negedge clk);
    chk("halt_seen", {31'd0, sawHalt}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t prog [24];
    prog[0]  = '{16'h0000, 16'hC105, EvReg,  3'd1, 16'h0005, 16'h0000}; // LBI R1,5
    prog[1]  = '{16'h0002, 16'hC2FF, EvReg,  3'd2, 16'hFFFF, 16'h0000}; // LBI R2,-1
    prog[2]  = '{16'h0004, 16'hD94C, EvReg,  3'd3, 16'h0004, 16'h0000}; // ADD R3=R1+R2
    prog[3]  = '{16'h0006, 16'h8022, EvSt,   3'd0, 16'h0005, 16'h0002}; // ST R1,[R0+2]
    prog[4]  = '{16'h0008, 16'h8882, EvLd,   3'd4, 16'h0005, 16'h0002}; // LD R4,[R0+2]
    prog[5]  = '{16'h000A, 16'h49A5, EvReg,  3'd5, 16'h0000, 16'h0000}; // SUBI R5=5-R1
    prog[6]  = '{16'h000C, 16'h5921, EvReg,  3'd1, 16'h0004, 16'h0000}; // ANDNI R1,1
    prog[7]  = '{16'h000E, 16'h52DF, EvReg,  3'd6, 16'hFFE0, 16'h0000}; // XORI R6=R2^1F
    prog[8]  = '{16'h0010, 16'hDCDD, EvReg,  3'd7, 16'hFFDB, 16'h0000}; // SUB R7=R6-R4
    prog[9]  = '{16'h0012, 16'hDF62, EvReg,  3'd0, 16'hFFDF, 16'h0000}; // XOR R0=R7^R3
    prog[10] = '{16'h0014, 16'hDAEB, EvReg,  3'd2, 16'h0024, 16'h0000}; // ANDN R2=R2&~R7
    prog[11] = '{16'h0016, 16'h4370, EvReg,  3'd3, 16'hFFF4, 16'h0000}; // ADDI R3,-16
    prog[12] = '{16'h0018, 16'h6504, EvNone, 3'd0, 16'h0000, 16'h0000}; // BEQZ R5,+4 taken
    prog[13] = '{16'h001A, 16'hC7AA, EvSkip, 3'd0, 16'h0000, 16'h0000};
    prog[14] = '{16'h001C, 16'hC7AA, EvSkip, 3'd0, 16'h0000, 16'h0000};
    prog[15] = '{16'h001E, 16'h6D04, EvNone, 3'd0, 16'h0000, 16'h0000}; // BNEZ R5 falls through
    prog[16] = '{16'h0020, 16'h6802, EvNone, 3'd0, 16'h0000, 16'h0000}; // BNEZ R0,+2 taken
    prog[17] = '{16'h0022, 16'hC7AA, EvSkip, 3'd0, 16'h0000, 16'h0000};
    prog[18] = '{16'h0024, 16'h2002, EvNone, 3'd0, 16'h0000, 16'h0000}; // J +2
    prog[19] = '{16'h0026, 16'hC7AA, EvSkip, 3'd0, 16'h0000, 16'h0000};
    prog[20] = '{16'h0028, 16'hF800, EvNone, 3'd0, 16'h0000, 16'h0000}; // unknown opcode
    prog[21] = '{16'h002A, 16'h0800, EvNone, 3'd0, 16'h0000, 16'h0000}; // NOP
    prog[22] = '{16'h002C, 16'h8CBD, EvLd,   3'd5, 16'h0005, 16'h0002}; // LD R5,[R4-3]
    prog[23] = '{16'h002E, 16'h0000, EvHalt, 3'd0, 16'h0000, 16'h0000}; // HALT

    // Reset state and program load.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 24; i++) dut.mem[{1'b0, prog[i].addr[15:1]}] <= prog[i].inst;
    @(negedge clk);
    chk("rst_pc", {16'd0, trc.pc}, 32'd0);
    chk("rst_inst", {16'd0, trc.inst}, 32'h0800);
    chk("rst_cycle_count", trc.cycle_count, 32'd0);
    chk("rst_strobes", {28'd0, trc.reg_write, trc.mem_read, trc.mem_write, trc.halt}, 32'd0);
    for (int r = 0; r < 8; r++) chk("rst_reg", {16'd0, dut.regFile[r]}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      if (prog[i].kind != EvSkip) pcQ.push_back(prog[i].addr);
      case (prog[i].kind)
        EvReg:  evQ.push_back('{EvReg, prog[i].idx, prog[i].val, 16'h0000});
        EvSt:   evQ.push_back('{EvSt, 3'd0, prog[i].val, prog[i].maddr});
        EvLd: begin
          evQ.push_back('{EvLd, 3'd0, prog[i].val, prog[i].maddr});
          evQ.push_back('{EvReg, prog[i].idx, prog[i].val, 16'h0000});
        end
        EvHalt: evQ.push_back('{EvHalt, 3'd0, 16'h0000, 16'h0000});
        default: ;
      endcase
    end
    sawHalt = 1'b0;
    monEn = 1'b1;
    releaseReset();
    waitHalt(200);
    repeat (12) @(negedge clk);
    chk("prog_halt_cycle", haltCycle, 32'd78);
    chk("prog_pc_frozen", {16'd0, trc.pc}, 32'h002E);
    chk("prog_events_left", evQ.size(), 32'd0);
    chk("prog_fetches_left", pcQ.size(), 32'd0);
    monEn = 1'b0;

    // HALT at address 0: halt in the third cycle after release, then silence.
    enterReset();
    dut.mem[0] <= 16'h0000;
    evQ.delete();
    pcQ.delete();
    evQ.push_back('{EvHalt, 3'd0, 16'h0000, 16'h0000});
    pcQ.push_back(16'h0000);
    sawHalt = 1'b0;
    monEn = 1'b1;
    releaseReset();
    waitHalt(20);
    repeat (8) @(negedge clk);
    chk("halt0_cycle", haltCycle, 32'd2);
    chk("halt0_pc", {16'd0, trc.pc}, 32'd0);
    chk("halt0_events_left", evQ.size(), 32'd0);
    monEn = 1'b0;

    // J -2 at address 0 loops on itself.
    enterReset();
    dut.mem[0] <= 16'h27FE;
    evQ.delete();
    pcQ.delete();
    for (int i = 0; i < 4; i++) pcQ.push_back(16'h0000);
    monEn = 1'b1;
    releaseReset();
    repeat (16) @(negedge clk);
    chk("jloop_fetches_left", pcQ.size(), 32'd0);
    monEn = 1'b0;

    // Reset landing on the MEM cycle of a store aborts it.
    enterReset();
    dut.mem[0] <= 16'hC105;
    dut.mem[1] <= 16'h8022;
    dut.mem[2] <= 16'h0000;
    releaseReset();
    for (int i = 0; i < 20 && tbCycle != 32'd6; i++) @(negedge clk);
    chk("abort_in_mem_write", {31'd0, trc.mem_write}, 32'd1);
    chk("abort_mem_addr", {16'd0, trc.mem_addr}, 32'h0002);
    chk("abort_r1_before", {16'd0, dut.regFile[1]}, 32'h0005);
    rst_n = 1'b0;
    #1;
    chk("abort_strobe_gated", {31'd0, trc.mem_write}, 32'd0);
    @(negedge clk);
    chk("abort_mem_kept", {16'd0, dut.mem[1]}, 32'h8022);
    chk("abort_pc", {16'd0, trc.pc}, 32'd0);
    chk("abort_cycle_count", trc.cycle_count, 32'd0);
    chk("abort_inst", {16'd0, trc.inst}, 32'h0800);
    for (int r = 0; r < 8; r++) chk("abort_reg", {16'd0, dut.regFile[r]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
